// File: rtl/binary_centroid.sv
// Blob centroid of a binarized 640x480 stream: per-frame white count and x/y sums, then a 28-step restoring divide.
// Result is held behind result_valid/result_ready; a frame ending while a result is pending is dropped and flagged by overrun.
module binary_centroid #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int MIN_COUNT = 16,
    parameter int DIV_STEPS = 28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_enable,
    input  logic        frame_enable,
    input  logic [15:0] pixel_color,
    input  logic        result_ready,
    output logic        result_valid,
    output logic [9:0]  centroid_x,
    output logic [9:0]  centroid_y,
    output logic [18:0] pixel_count,
    output logic        found,
    output logic        busy,
    output logic        overrun
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]  state;
    logic [9:0]  pos_x, pos_y;
    logic        fe_d;
    logic [18:0] cnt_acc, cnt_s;
    logic [27:0] sx_acc, sy_acc, sx_s, sy_s;
    logic [19:0] rem_x, rem_y, nrx, nry;
    logic [9:0]  qx, qy;
    logic [4:0]  step;
    logic        accept, frame_end, bit_x, bit_y;
    logic [20:0] tx, ty;

    assign accept    = frame_enable && clk_enable && (pos_y < 10'(V_ACTIVE))
                       && (pixel_color == 16'hFFFF);
    assign frame_end = fe_d && !frame_enable;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x <= '0;
            pos_y <= '0;
            fe_d  <= 1'b0;
        end else begin
            fe_d <= frame_enable;
            if (!frame_enable) begin
                pos_x <= '0;
                pos_y <= '0;
            end else if (clk_enable && pos_y != 10'(V_ACTIVE)) begin
                if (pos_x == 10'(H_ACTIVE - 1)) begin
                    pos_x <= '0;
                    pos_y <= pos_y + 10'd1;
                end else begin
                    pos_x <= pos_x + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_acc <= '0;
            sx_acc  <= '0;
            sy_acc  <= '0;
        end else if (frame_end) begin
            cnt_acc <= '0;
            sx_acc  <= '0;
            sy_acc  <= '0;
        end else if (accept) begin
            cnt_acc <= cnt_acc + 19'd1;
            sx_acc  <= sx_acc + 28'(pos_x);
            sy_acc  <= sy_acc + 28'(pos_y);
        end
    end

    // One restoring-division step for each axis; the dividend shifts out MSB first.
    always_comb begin
        tx    = {rem_x, sx_s[27]};
        ty    = {rem_y, sy_s[27]};
        bit_x = (tx >= 21'(cnt_s));
        bit_y = (ty >= 21'(cnt_s));
        nrx   = bit_x ? 20'(tx - 21'(cnt_s)) : 20'(tx);
        nry   = bit_y ? 20'(ty - 21'(cnt_s)) : 20'(ty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt_s        <= '0;
            sx_s         <= '0;
            sy_s         <= '0;
            rem_x        <= '0;
            rem_y        <= '0;
            qx           <= '0;
            qy           <= '0;
            step         <= '0;
            result_valid <= 1'b0;
            centroid_x   <= '0;
            centroid_y   <= '0;
            pixel_count  <= '0;
            found        <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= frame_end && (state != IDLE);
            case (state)
                IDLE: begin
                    if (frame_end) begin
                        cnt_s <= cnt_acc;
                        sx_s  <= sx_acc;
                        sy_s  <= sy_acc;
                        rem_x <= '0;
                        rem_y <= '0;
                        qx    <= '0;
                        qy    <= '0;
                        step  <= '0;
                        if (cnt_acc >= 19'(MIN_COUNT)) begin
                            state <= DIV;
                        end else begin
                            state       <= HOLD;
                            centroid_x  <= '0;
                            centroid_y  <= '0;
                            found       <= 1'b0;
                            pixel_count <= cnt_acc;
                        end
                    end
                end
                DIV: begin
                    sx_s  <= {sx_s[26:0], 1'b0};
                    sy_s  <= {sy_s[26:0], 1'b0};
                    rem_x <= nrx;
                    rem_y <= nry;
                    qx    <= {qx[8:0], bit_x};
                    qy    <= {qy[8:0], bit_y};
                    step  <= step + 5'd1;
                    if (step == 5'(DIV_STEPS - 1)) begin
                        centroid_x  <= {qx[8:0], bit_x};
                        centroid_y  <= {qy[8:0], bit_y};
                        found       <= 1'b1;
                        pixel_count <= cnt_s;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // result_valid trails entry into HOLD by one edge, so the outputs are settled when it rises.
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        result_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_binary_centroid.sv
// Directed bench for binary_centroid on a reduced 32x24 frame with MIN_COUNT=4.
module tb_binary_centroid;
    localparam int H = 32;
    localparam int V = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_enable = 1'b0;
    logic        frame_enable = 1'b0;
    logic [15:0] pixel_color = 16'h0000;
    logic        result_ready = 1'b0;
    logic        result_valid;
    logic [9:0]  centroid_x, centroid_y;
    logic [18:0] pixel_count;
    logic        found, busy, overrun;

    int total = 0;
    int bad = 0;
    int lat;

    binary_centroid #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_COUNT(4), .DIV_STEPS(28)) dut (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .frame_enable(frame_enable),
        .pixel_color(pixel_color), .result_ready(result_ready), .result_valid(result_valid),
        .centroid_x(centroid_x), .centroid_y(centroid_y), .pixel_count(pixel_count),
        .found(found), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind 0: empty, 1: 5x5 at x10..14 y5..9, 2: all white, 4: 3x3 at x10..12 y20..22
    function automatic logic [15:0] pix(input int kind, input int x, input int y);
        case (kind)
            1: return (x >= 10 && x <= 14 && y >= 5 && y <= 9) ? 16'hFFFF : 16'h0000;
            2: return 16'hFFFF;
            4: return (x >= 10 && x <= 12 && y >= 20 && y <= 22) ? 16'hFFFF : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    // Streams one frame; returns just after the frame-end edge.
    task automatic send_frame(input int kind);
        frame_enable = 1'b1;
        if (kind == 3) begin
            for (int i = 0; i < 50; i++) begin
                clk_enable  = 1'b1;
                pixel_color = (i % 2) ? 16'h8000 : 16'hFFFE;
                tick();
                clk_enable  = 1'b0;
                pixel_color = 16'hFFFF;
                tick();
            end
        end else begin
            for (int y = 0; y < V; y++) begin
                for (int x = 0; x < H; x++) begin
                    clk_enable  = 1'b1;
                    pixel_color = pix(kind, x, y);
                    tick();
                end
            end
            if (kind == 2) begin
                // Past the last line the counters saturate; these must not count.
                for (int i = 0; i < 40; i++) begin
                    pixel_color = 16'hFFFF;
                    tick();
                end
            end
        end
        frame_enable = 1'b0;
        clk_enable   = 1'b0;
        pixel_color  = 16'h0000;
        tick();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        // Reset asserted mid-frame.
        tick();
        rst_n = 1'b1;
        tick();
        frame_enable = 1'b1;
        clk_enable   = 1'b1;
        pixel_color  = 16'hFFFF;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", pixel_count, 0);
        chk("rst_cx", centroid_x, 0);
        chk("rst_found", found, 0);
        chk("rst_overrun", overrun, 0);
        frame_enable = 1'b0;
        clk_enable   = 1'b0;
        pixel_color  = 16'h0000;
        tick();
        rst_n = 1'b1;
        tick();

        // Empty frame: below threshold.
        send_frame(0);
        chk("empty_busy", busy, 1);
        wait_valid(lat);
        chk("empty_lat", lat, 1);
        chk("empty_valid", result_valid, 1);
        chk("empty_found", found, 0);
        chk("empty_count", pixel_count, 0);
        chk("empty_cxy", {centroid_x, centroid_y}, 0);
        handshake();
        chk("empty_drop", result_valid, 0);

        // 5x5 block.
        send_frame(1);
        chk("blk_busy", busy, 1);
        wait_valid(lat);
        chk("blk_lat", lat, 29);
        chk("blk_count", pixel_count, 25);
        chk("blk_cx", centroid_x, 12);
        chk("blk_cy", centroid_y, 7);
        chk("blk_found", found, 1);
        handshake();
        chk("blk_idle", busy, 0);

        // All white, with saturation tail.
        send_frame(2);
        wait_valid(lat);
        chk("white_lat", lat, 29);
        chk("white_count", pixel_count, H * V);
        chk("white_cx", centroid_x, 15);
        chk("white_cy", centroid_y, 11);
        chk("white_found", found, 1);
        handshake();

        // Near-white colours and strobe-less white pixels.
        send_frame(3);
        wait_valid(lat);
        chk("color_lat", lat, 1);
        chk("color_count", pixel_count, 0);
        chk("color_found", found, 0);
        handshake();

        // Backpressure across a second frame end.
        send_frame(1);
        wait_valid(lat);
        chk("bp_lat", lat, 29);
        repeat (5) tick();
        send_frame(4);
        chk("bp_overrun", overrun, 1);
        tick();
        chk("bp_overrun_end", overrun, 0);
        chk("bp_valid", result_valid, 1);
        chk("bp_cx", centroid_x, 12);
        chk("bp_cy", centroid_y, 7);
        chk("bp_count", pixel_count, 25);
        handshake();
        chk("bp_drop", result_valid, 0);
        chk("bp_idle", busy, 0);

        // Third frame with result_ready already high (ignored outside HOLD).
        result_ready = 1'b1;
        send_frame(4);
        chk("f3_overrun", overrun, 0);
        wait_valid(lat);
        chk("f3_lat", lat, 29);
        chk("f3_cx", centroid_x, 11);
        chk("f3_cy", centroid_y, 21);
        chk("f3_count", pixel_count, 9);
        tick();
        chk("f3_drop", result_valid, 0);
        result_ready = 1'b0;

        // Reset 10 cycles into DIV.
        send_frame(1);
        repeat (10) tick();
        chk("div_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("divrst_valid", result_valid, 0);
        chk("divrst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("divrst_novalid", result_valid, 0);
        send_frame(4);
        wait_valid(lat);
        chk("post_lat", lat, 29);
        chk("post_cx", centroid_x, 11);
        chk("post_cy", centroid_y, 21);
        chk("post_found", found, 1);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
